// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//
// Bundles the hazard-detection inputs gathered from the pipeline with the
// enable/flush controls, the halt flag and the performance counters that the
// hazard controller drives back into the datapath.
//
// Parameters:
//   CNT_W        width of the stall and flush counters
//
// Signals (direction as seen by the hazard controller, modport master):
//   ihit         in   instruction fetch for the current PC completes
//   dhit         in   MEM-stage data access completes
//   dc_rsel1     in   rs of the instruction in decode
//   dc_rsel2     in   rt of the instruction in decode
//   dc_uses_rt   in   decode instruction reads rt
//   ex_d_ren     in   EX-stage instruction is a load
//   ex_wsel      in   EX-stage destination register
//   mem_dreq     in   MEM-stage instruction performs a data access
//   br_taken     in   EX stage resolved a taken control transfer
//   wb_halt      in   halt instruction has reached WB
//   pc_en        out  PC load enable
//   pipe1_en..4  out  enables for if_dc, dc_ex, ex_mem, mem_wb
//   hz_flushed1  out  bubble insert into if_dc (overrides pipe1_en)
//   hz_flushed2  out  bubble insert into dc_ex (overrides pipe2_en)
//   halted       out  core halted (sticky until reset)
//   stall_cnt    out  saturating count of stalled cycles
//   flush_cnt    out  saturating count of branch squash events
//
// Modports:
//   master  the hazard controller
//   slave   the datapath that supplies status and consumes the controls
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic [4:0]       dc_rsel1;
    logic [4:0]       dc_rsel2;
    logic             dc_uses_rt;
    logic             ex_d_ren;
    logic [4:0]       ex_wsel;
    logic             mem_dreq;
    logic             br_taken;
    logic             wb_halt;

    logic             pc_en;
    logic             pipe1_en;
    logic             pipe2_en;
    logic             pipe3_en;
    logic             pipe4_en;
    logic             hz_flushed1;
    logic             hz_flushed2;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  ihit, dhit, dc_rsel1, dc_rsel2, dc_uses_rt,
               ex_d_ren, ex_wsel, mem_dreq, br_taken, wb_halt,
        output pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
               hz_flushed1, hz_flushed2, halted, stall_cnt, flush_cnt
    );

    modport slave (
        output ihit, dhit, dc_rsel1, dc_rsel2, dc_uses_rt,
               ex_d_ren, ex_wsel, mem_dreq, br_taken, wb_halt,
        input  pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
               hz_flushed1, hz_flushed2, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and stall controller for the 5-stage core. Generates the
// PC enable and the per-register enable/flush controls for if_dc, dc_ex,
// ex_mem and mem_wb. It sequences data-memory wait, load-use bubbles,
// taken-branch squashes, instruction-fetch wait and the terminal halt, and
// keeps saturating stall and flush event counters for performance debug.
//
// Parameters:
//   CNT_W  width of stall_cnt / flush_cnt
//
// Ports:
//   CLK    in  clock, rising edge
//   nRST   in  asynchronous active-low reset
//   hz     hazard_ctrl_if.master; status inputs, control outputs, halted
//          flag and counters (see hazard_ctrl_if.sv)
//
// The enable/flush outputs and halted are combinational (Mealy) from the
// registered state and the live inputs; state and counters are registered.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    hazard_ctrl_if.master hz
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Which decode rule won this cycle, in priority order.
    typedef enum logic [2:0] {
        SEL_HALT    = 3'd0,
        SEL_DSTALL  = 3'd1,
        SEL_BRANCH  = 3'd2,
        SEL_LOADUSE = 3'd3,
        SEL_FETCH   = 3'd4,
        SEL_RUN     = 3'd5
    } sel_t;

    state_t           state;
    state_t           next_state;
    sel_t             sel;

    logic             dstall;
    logic             load_use;
    logic             rs_match;
    logic             rt_match;

    logic             pc_en;
    logic             pipe1_en;
    logic             pipe2_en;
    logic             pipe3_en;
    logic             pipe4_en;
    logic             flushed1;
    logic             flushed2;

    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Hazard conditions. Register 0 is hard-wired zero, so a load targeting
    // it never creates a real dependency.
    always_comb begin
        dstall   = hz.mem_dreq && !hz.dhit;
        rs_match = (hz.ex_wsel == hz.dc_rsel1);
        rt_match = hz.dc_uses_rt && (hz.ex_wsel == hz.dc_rsel2);
        load_use = hz.ex_d_ren && (hz.ex_wsel != 5'd0) && (rs_match || rt_match);
    end

    // Priority selection. The state only matters for HALT: in DWAIT the
    // release cycle (dhit=1) falls through to the branch/load-use/fetch rules,
    // so a hazard hidden under the memory stall is honoured on release.
    always_comb begin
        sel = SEL_RUN;
        if ((state == HALT) || hz.wb_halt) begin
            sel = SEL_HALT;
        end else if (dstall) begin
            sel = SEL_DSTALL;
        end else if (hz.br_taken) begin
            sel = SEL_BRANCH;
        end else if (load_use) begin
            sel = SEL_LOADUSE;
        end else if (!hz.ihit) begin
            sel = SEL_FETCH;
        end
    end

    // Next-state logic. wb_halt beats every other transition.
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (hz.wb_halt) begin
                    next_state = HALT;
                end else if (dstall) begin
                    next_state = DWAIT;
                end
            end
            DWAIT: begin
                if (hz.wb_halt) begin
                    next_state = HALT;
                end else if (hz.dhit) begin
                    next_state = RUN;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Output decode. Flushes are never raised while the pipe is frozen;
    // on a taken branch pipe1/pipe2 stay enabled but the flushes override.
    always_comb begin
        pc_en    = 1'b1;
        pipe1_en = 1'b1;
        pipe2_en = 1'b1;
        pipe3_en = 1'b1;
        pipe4_en = 1'b1;
        flushed1 = 1'b0;
        flushed2 = 1'b0;
        case (sel)
            SEL_HALT, SEL_DSTALL: begin
                pc_en    = 1'b0;
                pipe1_en = 1'b0;
                pipe2_en = 1'b0;
                pipe3_en = 1'b0;
                pipe4_en = 1'b0;
            end
            SEL_BRANCH: begin
                flushed1 = 1'b1;
                flushed2 = 1'b1;
            end
            SEL_LOADUSE: begin
                pc_en    = 1'b0;
                pipe1_en = 1'b0;
                flushed2 = 1'b1;
            end
            SEL_FETCH: begin
                pc_en    = 1'b0;
                flushed1 = 1'b1;
            end
            default: begin
                pc_en    = 1'b1;
            end
        endcase
    end

    always_comb begin
        stall_inc = !pc_en && (sel != SEL_HALT);
        flush_inc = (sel == SEL_BRANCH);
    end

    // Saturating counters: hold at all-ones rather than wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.pipe1_en    = pipe1_en;
    assign hz.pipe2_en    = pipe2_en;
    assign hz.pipe3_en    = pipe3_en;
    assign hz.pipe4_en    = pipe4_en;
    assign hz.hz_flushed1 = flushed1;
    assign hz.hz_flushed2 = flushed2;
    assign hz.halted      = (sel == SEL_HALT);
    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Two instances share one stimulus
// stream: a 16-bit counter build and a 4-bit one for saturation. Expected
// values come from a priority-rule model with a sticky halt flag and
// unbounded integer counters clipped to the counter width.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic CLK;
    logic nRST;

    hazard_ctrl_if #(.CNT_W(16)) hz ();
    hazard_ctrl_if #(.CNT_W(4))  hz4 ();

    hazard_ctrl #(.CNT_W(16)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hz   (hz.master)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .CLK  (CLK),
        .nRST (nRST),
        .hz   (hz4.master)
    );

    assign hz4.ihit       = hz.ihit;
    assign hz4.dhit       = hz.dhit;
    assign hz4.dc_rsel1   = hz.dc_rsel1;
    assign hz4.dc_rsel2   = hz.dc_rsel2;
    assign hz4.dc_uses_rt = hz.dc_uses_rt;
    assign hz4.ex_d_ren   = hz.ex_d_ren;
    assign hz4.ex_wsel    = hz.ex_wsel;
    assign hz4.mem_dreq   = hz.mem_dreq;
    assign hz4.br_taken   = hz.br_taken;
    assign hz4.wb_halt    = hz.wb_halt;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        bit       ihit;
        bit       dhit;
        bit [4:0] rsel1;
        bit [4:0] rsel2;
        bit       uses_rt;
        bit       ex_d_ren;
        bit [4:0] ex_wsel;
        bit       mem_dreq;
        bit       br_taken;
        bit       wb_halt;
    } stim_t;

    // exp bit order: {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en, flushed1, flushed2}
    typedef struct {
        stim_t    s;
        bit [6:0] exp;
    } vec_t;

    int tests;
    int fails;

    bit          m_halt;
    int unsigned m_stall;
    int unsigned m_flush;

    function automatic stim_t mk(bit ih, bit dh, bit [4:0] r1, bit [4:0] r2, bit ut,
                                 bit ld, bit [4:0] ws, bit mq, bit br, bit hl);
        stim_t s;
        s.ihit = ih; s.dhit = dh; s.rsel1 = r1; s.rsel2 = r2; s.uses_rt = ut;
        s.ex_d_ren = ld; s.ex_wsel = ws; s.mem_dreq = mq; s.br_taken = br; s.wb_halt = hl;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    endfunction

    function automatic int unsigned sat(int unsigned v, int w);
        int unsigned lim;
        lim = (32'd1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic bit is_frozen(stim_t s);
        return m_halt || s.wb_halt || (s.mem_dreq && !s.dhit);
    endfunction

    function automatic bit is_load_use(stim_t s);
        if (!s.ex_d_ren || s.ex_wsel == 0) return 0;
        return (s.ex_wsel == s.rsel1) || (s.uses_rt && s.ex_wsel == s.rsel2);
    endfunction

    // Reference rules, first match wins.
    function automatic bit [6:0] exp_ctrl(stim_t s);
        if (is_frozen(s))    return 7'b0000000;
        if (s.br_taken)      return 7'b1111111;
        if (is_load_use(s))  return 7'b0011101;
        if (!s.ihit)         return 7'b0111110;
        return 7'b1111100;
    endfunction

    function automatic bit [6:0] dut_ctrl();
        return {hz.pc_en, hz.pipe1_en, hz.pipe2_en, hz.pipe3_en, hz.pipe4_en,
                hz.hz_flushed1, hz.hz_flushed2};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(stim_t s);
        hz.ihit       = s.ihit;
        hz.dhit       = s.dhit;
        hz.dc_rsel1   = s.rsel1;
        hz.dc_rsel2   = s.rsel2;
        hz.dc_uses_rt = s.uses_rt;
        hz.ex_d_ren   = s.ex_d_ren;
        hz.ex_wsel    = s.ex_wsel;
        hz.mem_dreq   = s.mem_dreq;
        hz.br_taken   = s.br_taken;
        hz.wb_halt    = s.wb_halt;
    endtask

    // Called just after a falling edge: drive, check mid-cycle, advance model
    // on the rising edge, return at the next falling edge.
    task automatic applyStimulus(input stim_t s, input bit use_tbl, input bit [6:0] tbl_exp);
        bit [6:0] e;
        drive(s);
        #1;
        e = exp_ctrl(s);
        checkOutput("ctrl", {25'd0, dut_ctrl()}, {25'd0, e});
        if (use_tbl) checkOutput("table_ctrl", {25'd0, dut_ctrl()}, {25'd0, tbl_exp});
        checkOutput("halted",     {31'd0, hz.halted},  {31'd0, m_halt || s.wb_halt});
        checkOutput("halted_w4",  {31'd0, hz4.halted}, {31'd0, m_halt || s.wb_halt});
        checkOutput("stall_cnt",  {16'd0, hz.stall_cnt}, sat(m_stall, 16));
        checkOutput("flush_cnt",  {16'd0, hz.flush_cnt}, sat(m_flush, 16));
        checkOutput("stall_cnt4", {28'd0, hz4.stall_cnt}, sat(m_stall, 4));
        checkOutput("flush_cnt4", {28'd0, hz4.flush_cnt}, sat(m_flush, 4));
        @(posedge CLK);
        if (!m_halt && !s.wb_halt && !e[6]) m_stall++;
        if (!is_frozen(s) && s.br_taken)    m_flush++;
        if (s.wb_halt)                      m_halt = 1;
        @(negedge CLK);
    endtask

    task automatic step(input stim_t s);
        applyStimulus(s, 0, 7'd0);
    endtask

    // Reset is asserted mid-cycle to show the clear is asynchronous.
    task automatic doReset();
        drive(idle());
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("rst_halted",    {31'd0, hz.halted},    32'd0);
        checkOutput("rst_stall_cnt", {16'd0, hz.stall_cnt}, 32'd0);
        checkOutput("rst_flush_cnt", {16'd0, hz.flush_cnt}, 32'd0);
        checkOutput("rst_stall4",    {28'd0, hz4.stall_cnt}, 32'd0);
        m_halt  = 0;
        m_stall = 0;
        m_flush = 0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    vec_t tbl[12];

    initial begin
        stim_t s;
        int    halt_cycles;

        tests = 0;
        fails = 0;
        m_halt = 0; m_stall = 0; m_flush = 0;
        nRST = 1'b0;
        drive(idle());

        tbl[0]  = '{mk(1,1,5'd0,5'd0,0,0,5'd0,0,0,0), 7'b1111100};
        tbl[1]  = '{mk(0,1,5'd0,5'd0,0,0,5'd0,0,0,0), 7'b0111110};
        tbl[2]  = '{mk(1,1,5'd5,5'd0,0,1,5'd5,0,0,0), 7'b0011101};
        tbl[3]  = '{mk(1,1,5'd0,5'd0,1,1,5'd0,0,0,0), 7'b1111100};
        tbl[4]  = '{mk(1,1,5'd1,5'd7,1,1,5'd7,0,0,0), 7'b0011101};
        tbl[5]  = '{mk(1,1,5'd1,5'd7,0,1,5'd7,0,0,0), 7'b1111100};
        tbl[6]  = '{mk(1,1,5'd5,5'd5,1,0,5'd5,0,0,0), 7'b1111100};
        tbl[7]  = '{mk(0,1,5'd5,5'd0,0,1,5'd5,0,1,0), 7'b1111111};
        tbl[8]  = '{mk(1,1,5'd0,5'd0,0,0,5'd0,1,0,0), 7'b1111100};
        tbl[9]  = '{mk(0,1,5'd3,5'd0,0,1,5'd3,0,0,0), 7'b0011101};
        tbl[10] = '{mk(1,1,5'd0,5'd0,0,0,5'd0,0,1,0), 7'b1111111};
        tbl[11] = '{mk(0,1,5'd0,5'd0,0,0,5'd0,1,0,0), 7'b0111110};

        #1;
        checkOutput("init_halted",    {31'd0, hz.halted},    32'd0);
        checkOutput("init_stall_cnt", {16'd0, hz.stall_cnt}, 32'd0);
        checkOutput("init_flush_cnt", {16'd0, hz.flush_cnt}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) applyStimulus(tbl[i].s, 1, tbl[i].exp);

        $display("[TB] load-use bubble");
        doReset();
        step(mk(1,1,5'd5,5'd0,0,1,5'd5,0,0,0));
        step(mk(1,1,5'd5,5'd0,0,0,5'd9,0,0,0));
        checkOutput("lu_stall_cnt", {16'd0, hz.stall_cnt}, 32'd1);

        $display("[TB] data-memory stall");
        doReset();
        for (int i = 0; i < 3; i++) step(mk(1,0,5'd0,5'd0,0,0,5'd0,1,0,0));
        step(mk(1,1,5'd0,5'd0,0,0,5'd0,1,0,0));
        checkOutput("ds_stall_cnt", {16'd0, hz.stall_cnt}, 32'd3);

        $display("[TB] branch over hazards");
        doReset();
        step(mk(0,1,5'd4,5'd0,0,1,5'd4,0,1,0));
        step(idle());
        checkOutput("bh_flush_cnt", {16'd0, hz.flush_cnt}, 32'd1);
        checkOutput("bh_stall_cnt", {16'd0, hz.stall_cnt}, 32'd0);

        $display("[TB] branch under data stall");
        doReset();
        step(mk(1,0,5'd0,5'd0,0,0,5'd0,1,0,0));
        step(mk(1,0,5'd0,5'd0,0,0,5'd0,1,1,0));
        step(mk(1,1,5'd0,5'd0,0,0,5'd0,1,1,0));
        step(idle());
        checkOutput("bd_flush_cnt", {16'd0, hz.flush_cnt}, 32'd1);
        checkOutput("bd_stall_cnt", {16'd0, hz.stall_cnt}, 32'd2);

        $display("[TB] halt");
        doReset();
        step(mk(0,1,5'd0,5'd0,0,0,5'd0,0,0,0));
        step(mk(1,1,5'd0,5'd0,0,0,5'd0,0,1,1));
        for (int i = 0; i < 12; i++) begin
            s = mk($urandom_range(0,1), $urandom_range(0,1), 5'($urandom_range(0,3)),
                   5'($urandom_range(0,3)), $urandom_range(0,1), $urandom_range(0,1),
                   5'($urandom_range(0,3)), $urandom_range(0,1), $urandom_range(0,1), 0);
            step(s);
        end
        checkOutput("halt_sticky", {31'd0, hz.halted}, 32'd1);
        checkOutput("halt_stall_cnt", {16'd0, hz.stall_cnt}, 32'd1);
        doReset();

        $display("[TB] counter saturation");
        for (int i = 0; i < 20; i++) step(mk(0,1,5'd0,5'd0,0,0,5'd0,0,0,0));
        checkOutput("sat_stall4",  {28'd0, hz4.stall_cnt}, 32'd15);
        checkOutput("sat_stall16", {16'd0, hz.stall_cnt},  32'd20);

        $display("[TB] random stimulus");
        doReset();
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            s = mk($urandom_range(0,9) < 8, $urandom_range(0,9) < 6,
                   5'($urandom_range(0,3)), 5'($urandom_range(0,3)), $urandom_range(0,1),
                   $urandom_range(0,9) < 4, 5'($urandom_range(0,3)),
                   $urandom_range(0,9) < 3, $urandom_range(0,99) < 15,
                   $urandom_range(0,199) == 0);
            step(s);
            if (m_halt) halt_cycles++;
            if (halt_cycles > 8) begin
                doReset();
                halt_cycles = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
